// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative dcache storage array: op codes,
// the tag-entry layout and the way-index width helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    DC_OP_LOOKUP = 2'd0,
    DC_OP_WRITE  = 2'd1,
    DC_OP_FILL   = 2'd2,
    DC_OP_RSVD   = 2'd3
  } dc_op_e;

  localparam int DC_TAG_W = 23;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [DC_TAG_W-1:0] tag;
  } dc_tag_entry_t;

  // A way index is never narrower than one bit, even for a 2-way cache.
  function automatic int clog2_ways(input int ways);
    return (ways > 2) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru_age.sv
// True-LRU age update for one set: ages form a permutation of 0..WAYS-1,
// 0 = most recently used. Purely combinational.
module dcache_lru_age #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS*WAY_W-1:0] age,
  input  logic [WAY_W-1:0]      touch_way,
  output logic [WAYS*WAY_W-1:0] age_next,
  output logic [WAY_W-1:0]      oldest
);

  logic [WAY_W-1:0] touch_age;
  logic [WAY_W-1:0] a;

  always_comb begin
    touch_age = age[int'(touch_way)*WAY_W +: WAY_W];
    age_next  = age;
    oldest    = '0;
    a         = '0;
    for (int w = 0; w < WAYS; w++) begin
      a = age[w*WAY_W +: WAY_W];
      if (WAY_W'(w) == touch_way)
        age_next[w*WAY_W +: WAY_W] = '0;
      else if (a < touch_age)
        age_next[w*WAY_W +: WAY_W] = a + WAY_W'(1);
      if (a == WAY_W'(WAYS-1))
        oldest = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU replacement and victim
// readout. Define DCACHE_STATS_EN to add saturating hit/miss counter ports.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter  int WAYS   = 2,
  parameter  int SETS   = 16,
  parameter  int TAG_W  = 23,
  parameter  int LINE_W = 256,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = clog2_ways(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [1:0]        op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              rsp_valid_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [LINE_W-1:0] data_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  logic [TAG_W-1:0]      tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]     data_mem [SETS][WAYS];
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [WAYS-1:0]       dirty_q  [SETS];
  logic [WAYS*WAY_W-1:0] age_q    [SETS];

  logic [WAYS*WAY_W-1:0] age_rst, age_next;
  logic                  hit, inv_found, vic_valid, is_write, is_fill;
  logic                  do_touch, do_line_wr, do_fill;
  logic [WAY_W-1:0]      hit_way, inv_way, oldest_way, vic_way, touch_way;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx_i][WAY_W'(w)] && tag_mem[idx_i][WAY_W'(w)] == tag_i) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx_i][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    age_rst = '0;
    for (int w = 0; w < WAYS; w++) age_rst[w*WAY_W +: WAY_W] = WAY_W'(w);
  end

  assign is_write   = (op_i == DC_OP_WRITE);
  assign is_fill    = (op_i == DC_OP_FILL);
  assign vic_way    = inv_found ? inv_way : oldest_way;
  assign vic_valid  = valid_q[idx_i][vic_way];
  // A FILL that hits rewrites the matching way, so a tag is never held twice.
  assign touch_way  = hit ? hit_way : vic_way;
  assign do_touch   = en_i && (hit || is_fill);
  assign do_fill    = en_i && is_fill;
  assign do_line_wr = do_fill || (en_i && is_write && hit);

  dcache_lru_age #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .age       (age_q[idx_i]),
    .touch_way (touch_way),
    .age_next  (age_next),
    .oldest    (oldest_way)
  );

  // Tag/line storage is never reset so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (do_line_wr) data_mem[idx_i][touch_way] <= data_i;
    if (do_fill)    tag_mem[idx_i][touch_way]  <= tag_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[IDX_W'(s)] <= '0;
        dirty_q[IDX_W'(s)] <= '0;
        age_q[IDX_W'(s)]   <= age_rst;
      end
    end else begin
      if (do_touch) age_q[idx_i] <= age_next;
      if (do_fill) begin
        valid_q[idx_i][touch_way] <= 1'b1;
        dirty_q[idx_i][touch_way] <= dirty_i;
      end else if (do_line_wr) begin
        dirty_q[idx_i][hit_way] <= 1'b1;
      end
    end
  end

  // Victim fields are zeroed unless the victim way holds a valid line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o    <= 1'b0;
      hit_o          <= 1'b0;
      way_o          <= '0;
      data_o         <= '0;
      victim_valid_o <= 1'b0;
      victim_dirty_o <= 1'b0;
      victim_tag_o   <= '0;
      victim_data_o  <= '0;
    end else begin
      rsp_valid_o <= en_i;
      if (en_i) begin
        hit_o          <= hit;
        way_o          <= touch_way;
        data_o         <= !hit ? '0 : (is_write || is_fill) ? data_i : data_mem[idx_i][hit_way];
        victim_valid_o <= !hit && vic_valid;
        victim_dirty_o <= !hit && vic_valid && dirty_q[idx_i][vic_way];
        victim_tag_o   <= (!hit && vic_valid) ? tag_mem[idx_i][vic_way] : '0;
        victim_data_o  <= (!hit && vic_valid) ? data_mem[idx_i][vic_way] : '0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (en_i && !is_fill) begin
      if (hit && hit_cnt_o != '1)        hit_cnt_o  <= hit_cnt_o + 32'd1;
      else if (!hit && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Bench for dcache_sram_nway: recency-list reference model, per-cycle compare
// process and directed literal checks, then randomized traffic.
module tb_dcache_sram_nway;
  import dcache_pkg::*;

  localparam int WAYS = 2, SETS = 16, TAG_W = 23, LINE_W = 256, IDX_W = 4, WAY_W = 1;

  logic              clk_i = 1'b0;
  logic              rst_i, en_i, dirty_i;
  logic [1:0]        op_i;
  logic [IDX_W-1:0]  idx_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              rsp_valid_o, hit_o, victim_valid_o, victim_dirty_o;
  logic [WAY_W-1:0]  way_o;
  logic [LINE_W-1:0] data_o, victim_data_o;
  logic [TAG_W-1:0]  victim_tag_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .op_i(op_i), .idx_i(idx_i),
    .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i),
    .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .way_o(way_o), .data_o(data_o),
    .victim_valid_o(victim_valid_o), .victim_dirty_o(victim_dirty_o),
    .victim_tag_o(victim_tag_o), .victim_data_o(victim_data_o)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic              rsp;
    logic              hit;
    logic [WAY_W-1:0]  way;
    logic [LINE_W-1:0] data;
    logic              vv;
    logic              vd;
    logic [TAG_W-1:0]  vtag;
    logic [LINE_W-1:0] vdata;
    logic [31:0]       hc;
    logic [31:0]       mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic              m_valid [SETS][WAYS];
  logic              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                recency [SETS][$];   // front = most recently used way
  logic [31:0]       m_hc, m_mc;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      recency[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        recency[s].push_back(w);
      end
    end
    m_hc = 0;
    m_mc = 0;
    last_exp = '0;
  endfunction

  function automatic void model_touch(input int s, input int w);
    for (int i = 0; i < recency[s].size(); i++)
      if (recency[s][i] == w) begin
        recency[s].delete(i);
        break;
      end
    recency[s].push_front(w);
  endfunction

  function automatic exp_t model_op(input logic [1:0] op, input int s, input logic [TAG_W-1:0] tag,
                                    input logic [LINE_W-1:0] data, input logic dirty);
    exp_t e;
    int   hw = -1, iw = -1, vw, tw;
    for (int w = 0; w < WAYS; w++) begin
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tag) hw = w;
      if (iw < 0 && !m_valid[s][w]) iw = w;
    end
    vw = (iw >= 0) ? iw : recency[s][recency[s].size()-1];
    tw = (hw >= 0) ? hw : vw;
    e = '0;
    e.rsp = 1'b1;
    e.hit = (hw >= 0);
    e.way = WAY_W'(tw);
    if (hw >= 0) begin
      e.data = (op == DC_OP_WRITE || op == DC_OP_FILL) ? data : m_data[s][hw];
    end else if (m_valid[s][vw]) begin
      e.vv = 1'b1;
      e.vd = m_dirty[s][vw];
      e.vtag = m_tag[s][vw];
      e.vdata = m_data[s][vw];
    end
    if (op != DC_OP_FILL) begin
      if (hw >= 0 && m_hc != 32'hFFFF_FFFF) m_hc++;
      if (hw < 0 && m_mc != 32'hFFFF_FFFF) m_mc++;
    end
    if (op == DC_OP_FILL) begin
      m_tag[s][tw] = tag;
      m_data[s][tw] = data;
      m_valid[s][tw] = 1'b1;
      m_dirty[s][tw] = dirty;
      model_touch(s, tw);
    end else if (hw >= 0) begin
      if (op == DC_OP_WRITE) begin
        m_data[s][hw] = data;
        m_dirty[s][hw] = 1'b1;
      end
      model_touch(s, hw);
    end
    e.hc = m_hc;
    e.mc = m_mc;
    return e;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_valid", LINE_W'(rsp_valid_o), LINE_W'(e.rsp));
        chk("hit", LINE_W'(hit_o), LINE_W'(e.hit));
        chk("way", LINE_W'(way_o), LINE_W'(e.way));
        chk("data", data_o, e.data);
        chk("victim_valid", LINE_W'(victim_valid_o), LINE_W'(e.vv));
        chk("victim_dirty", LINE_W'(victim_dirty_o), LINE_W'(e.vd));
        chk("victim_tag", LINE_W'(victim_tag_o), LINE_W'(e.vtag));
        chk("victim_data", victim_data_o, e.vdata);
`ifdef DCACHE_STATS_EN
        chk("hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(e.hc));
        chk("miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(e.mc));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic en, input logic [1:0] op, input int s, input logic [TAG_W-1:0] tag,
                       input logic [LINE_W-1:0] data, input logic dirty);
    exp_t e;
    @(negedge clk_i);
    en_i = en; op_i = op; idx_i = IDX_W'(s); tag_i = tag; data_i = data; dirty_i = dirty;
    if (en) begin
      e = model_op(op, s, tag, data, dirty);
    end else begin
      e = last_exp;
      e.rsp = 1'b0;
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  // Reset asserted together with a live request: that request must be dropped.
  task automatic do_reset(input logic with_req);
    @(negedge clk_i);
    rst_i = 1'b1; en_i = with_req; op_i = DC_OP_FILL; idx_i = '0; tag_i = 23'h7;
    model_reset();
    exp_q.push_back(last_exp);
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b0;
    exp_q.push_back(last_exp);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    logic [LINE_W-1:0] line_a, line_b, line_c;
    int budget;
    line_a = {8{32'hAAAA_0001}};
    line_b = {8{32'hBBBB_0002}};
    line_c = {8{32'hCCCC_0003}};
    rst_i = 1'b1; en_i = 1'b0; op_i = '0; idx_i = '0; tag_i = '0; data_i = '0; dirty_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_rsp_valid", LINE_W'(rsp_valid_o), '0);
    chk("reset_hit", LINE_W'(hit_o), '0);
    chk("reset_victim_valid", LINE_W'(victim_valid_o), '0);
    chk("reset_data", data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.push_back(last_exp);

    // Cold miss, then fill and hit.
    do_op(1, DC_OP_LOOKUP, 3, 23'h12, '0, 0);
    settle();
    chk("cold_rsp_valid", LINE_W'(rsp_valid_o), LINE_W'(1));
    chk("cold_hit", LINE_W'(hit_o), '0);
    chk("cold_way", LINE_W'(way_o), '0);
    chk("cold_victim_valid", LINE_W'(victim_valid_o), '0);
    do_op(1, DC_OP_FILL, 3, 23'h12, line_a, 0);
    do_op(1, DC_OP_LOOKUP, 3, 23'h12, '0, 0);
    settle();
    chk("fill_hit", LINE_W'(hit_o), LINE_W'(1));
    chk("fill_data", data_o, line_a);

    // LRU eviction on set 5.
    do_op(1, DC_OP_FILL, 5, 23'h1, rand_line(), 0);
    do_op(1, DC_OP_FILL, 5, 23'h2, rand_line(), 0);
    do_op(1, DC_OP_LOOKUP, 5, 23'h1, '0, 0);
    do_op(1, DC_OP_FILL, 5, 23'h3, rand_line(), 0);
    settle();
    chk("evict_way", LINE_W'(way_o), LINE_W'(1));
    chk("evict_victim_tag", LINE_W'(victim_tag_o), LINE_W'(23'h2));

    // Dirty write-back of a written line.
    do_op(1, DC_OP_WRITE, 5, 23'h1, line_b, 0);
    do_op(1, DC_OP_LOOKUP, 5, 23'h3, '0, 0);
    do_op(1, DC_OP_FILL, 5, 23'h4, rand_line(), 0);
    settle();
    chk("wb_victim_dirty", LINE_W'(victim_dirty_o), LINE_W'(1));
    chk("wb_victim_tag", LINE_W'(victim_tag_o), LINE_W'(23'h1));
    chk("wb_victim_data", victim_data_o, line_b);

    // FILL of a resident tag rewrites in place.
    do_op(1, DC_OP_FILL, 5, 23'h3, line_c, 1);
    settle();
    chk("refill_hit", LINE_W'(hit_o), LINE_W'(1));
    chk("refill_way", LINE_W'(way_o), LINE_W'(1));
    chk("refill_no_victim", LINE_W'(victim_valid_o), '0);
    do_op(1, DC_OP_LOOKUP, 5, 23'h3, '0, 0);
    settle();
    chk("refill_data", data_o, line_c);

    // Counter scenario: 2 misses, a fill, 3 hits.
    do_reset(0);
    do_op(1, DC_OP_LOOKUP, 8, 23'h9, '0, 0);
    do_op(1, DC_OP_WRITE, 8, 23'h9, rand_line(), 0);
    do_op(1, DC_OP_FILL, 8, 23'h9, rand_line(), 0);
    for (int i = 0; i < 3; i++) do_op(1, DC_OP_LOOKUP, 8, 23'h9, '0, 0);
    settle();
`ifdef DCACHE_STATS_EN
    chk("stats_hits", LINE_W'(hit_cnt_o), LINE_W'(3));
    chk("stats_misses", LINE_W'(miss_cnt_o), LINE_W'(2));
`endif
    do_reset(1);
`ifdef DCACHE_STATS_EN
    chk("stats_clear_hits", LINE_W'(hit_cnt_o), '0);
    chk("stats_clear_misses", LINE_W'(miss_cnt_o), '0);
`endif
    do_op(0, DC_OP_LOOKUP, 0, '0, '0, 0);
    settle();
    chk("post_reset_rsp_valid", LINE_W'(rsp_valid_o), '0);

    // Randomized traffic on a few sets with a narrow tag space.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      do_op($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
            TAG_W'($urandom_range(0, 5)), rand_line(), 1'($urandom_range(0, 1)));
    end
    do_op(0, DC_OP_LOOKUP, 0, '0, '0, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk_i);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
